mining_controller: RTL
======================

MINING_CONTROLLER -- requirements
Module: mining_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles in WAIT before core_done (used only with MINER_TIMEOUT_EN).
REQ-002 SHALL have ports, one clock, reset asynchronous active-low:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  start  in  1  begin nonce sweep (sampled in IDLE)
  abort  in  1  terminate sweep
  header_in  in  640  block header; bits [31:0] (nonce field) ignored
  nonce_start  in  32  first nonce, inclusive
  nonce_end  in  32  last nonce, inclusive
  target  in  256  unsigned difficulty target
  core_start  out  1  one-cycle start pulse to the double-SHA-256 hash core
  core_header  out  640  header presented to the core
  core_done  in  1  core result valid, one-cycle pulse
  core_hash  in  256  core digest, unsigned
  busy  out  1  high in any state except IDLE
  done  out  1  one-cycle pulse at sweep end
  found  out  1  last sweep met target
  nonce_out  out  32  winning nonce
  hash_count  out  32  core results accepted in current sweep
  error  out  1  core timeout flag

Function
REQ-003 States: IDLE, ISSUE, WAIT, CHECK, FINISH (plus TIMEOUT when MINER_TIMEOUT_EN).
REQ-004 IDLE: start=1 and abort=0 SHALL latch header_in[639:32], nonce_start, nonce_end, target; nonce<=nonce_start; hash_count<=0; found<=0; error<=0; go ISSUE.
REQ-005 start while busy=1 SHALL be ignored; latched values SHALL not change mid-sweep.
REQ-006 core_header SHALL equal {latched header[639:32], nonce} in ISSUE and WAIT, and hold its last value otherwise.
REQ-007 ISSUE: core_start=1 for exactly one cycle; next state WAIT.
REQ-008 WAIT: core_done=1 SHALL capture core_hash, increment hash_count (modulo 2^32), go CHECK; otherwise stay.
REQ-009 core_done outside WAIT SHALL be ignored (no capture, no count).
REQ-010 CHECK: captured hash <= target (unsigned 256-bit) SHALL set found=1, nonce_out=nonce, go FINISH.
REQ-011 CHECK, no hit, nonce==nonce_end: found stays 0, go FINISH.
REQ-012 CHECK, no hit, nonce!=nonce_end: nonce<=nonce+1 modulo 2^32 (0xFFFFFFFF wraps to 0), go ISSUE; start>end sweeps through wrap.
REQ-013 nonce_start==nonce_end SHALL test exactly one nonce.
REQ-014 Per-nonce latency: ISSUE 1 cycle + WAIT (core dependent, >=1) + CHECK 1 cycle.
REQ-015 FINISH: done=1 for one cycle; next state IDLE; found, nonce_out, hash_count, error hold until next accepted start.
REQ-016 abort=1 in any non-IDLE state SHALL go IDLE next cycle, no done pulse, found=0; abort has priority over core_done, start and CHECK outcome (same-cycle core_done discarded, not counted).
REQ-017 abort in IDLE SHALL have no effect; simultaneous start and abort in IDLE SHALL remain IDLE.

Reset
REQ-018 rst_n=0 SHALL asynchronously force IDLE and core_start, busy, done, found, error=0; nonce_out, hash_count, core_header=0; internal nonce and latches=0.
REQ-019 Reset mid-sweep SHALL drop the sweep; a later core_done SHALL be ignored.
REQ-020 Outputs SHALL be registered; release of rst_n SHALL take effect on the first following rising clk edge.

Configuration
REQ-021 Macro MINER_TIMEOUT_EN defined: WAIT counts cycles from entry; reaching TIMEOUT_CYCLES without core_done SHALL enter TIMEOUT, which sets error=1, found=0, pulses done, returns IDLE next cycle; counter clears on each WAIT entry.
REQ-022 MINER_TIMEOUT_EN undefined: no counter, no TIMEOUT state, error tied 0, WAIT waits indefinitely, TIMEOUT_CYCLES unused.

Verification
REQ-023 Model core, 3-cycle latency; nonce_start=0x10, nonce_end=0x14, hash<=target only at 0x12 -> done pulse, found=1, nonce_out=0x12, hash_count=3.
REQ-024 nonce_start=0xFFFFFFFE, nonce_end=0x00000001, no hit -> nonces FFFFFFFE, FFFFFFFF, 0, 1 issued in order; done, found=0, hash_count=4.
REQ-025 abort asserted in WAIT of second nonce, core_done same cycle -> IDLE next cycle, no done, hash_count=1, core_start stays 0.
REQ-026 core_hash == target exactly, nonce_start==nonce_end=0x7 -> found=1, nonce_out=0x7, one core_start pulse total.
REQ-027 MINER_TIMEOUT_EN, TIMEOUT_CYCLES=16, core never responds -> done and error=1 at WAIT cycle 16; undefined build: busy stays 1 after 1000 cycles, error=0.
REQ-028 rst_n low mid-WAIT, then core_done pulse -> all outputs 0, state IDLE, hash_count=0.

Source files
------------

// File: rtl/mining_controller.sv
// Nonce-sweep controller that drives an external double-SHA-256 core and compares digests to target.
// Define MINER_TIMEOUT_EN to add a core watchdog (TIMEOUT state, error flag).
module mining_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] header_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [255:0] target,
    output logic         core_start,
    output logic [639:0] core_header,
    input  logic         core_done,
    input  logic [255:0] core_hash,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [31:0]  hash_count,
    output logic         error
);

`ifdef MINER_TIMEOUT_EN
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StFinish, StTimeout} state_e;
`else
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StCheck, StFinish} state_e;
`endif

    state_e         state_q, state_d;
    logic [607:0]   hdr_q;
    logic [31:0]    nonce_q, end_q;
    logic [255:0]   target_q, hash_q;
    logic           hit, accept, capture, advance, win, aborting;

    // The nonce field of the incoming header is replaced by the sweep nonce.
    logic [31:0] unused_nonce_field;
    assign unused_nonce_field = header_in[31:0];

    assign hit      = (hash_q <= target_q);
    assign aborting = abort && (state_q != StIdle);
    assign accept   = (state_q == StIdle)  && (state_d == StIssue);
    assign capture  = (state_q == StWait)  && (state_d == StCheck);
    assign advance  = (state_q == StCheck) && (state_d == StIssue);
    assign win      = (state_q == StCheck) && (state_d == StFinish) && hit;

`ifdef MINER_TIMEOUT_EN
    logic [31:0] wait_cnt_q;
    logic        wait_expired;

    assign wait_expired = (wait_cnt_q == TIMEOUT_CYCLES - 1);

    // Cleared whenever outside WAIT, so every WAIT entry starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != StWait) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error <= 1'b0;
        end else if (accept) begin
            error <= 1'b0;
        end else if (state_d == StTimeout) begin
            error <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign error          = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !abort) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (core_done) state_d = StCheck;
`ifdef MINER_TIMEOUT_EN
                else if (wait_expired) state_d = StTimeout;
`endif
            end
            StCheck: state_d = (hit || nonce_q == end_q) ? StFinish : StIssue;
            default: state_d = StIdle;
        endcase
        // Abort outranks core_done and the CHECK outcome.
        if (aborting) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            hdr_q       <= '0;
            nonce_q     <= '0;
            end_q       <= '0;
            target_q    <= '0;
            hash_q      <= '0;
            core_start  <= 1'b0;
            core_header <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            nonce_out   <= '0;
            hash_count  <= '0;
        end else begin
            state_q    <= state_d;
            busy       <= (state_d != StIdle);
            core_start <= (state_d == StIssue);
`ifdef MINER_TIMEOUT_EN
            done       <= (state_d == StFinish) || (state_d == StTimeout);
`else
            done       <= (state_d == StFinish);
`endif
            if (accept) begin
                hdr_q       <= header_in[639:32];
                end_q       <= nonce_end;
                target_q    <= target;
                nonce_q     <= nonce_start;
                hash_count  <= '0;
                found       <= 1'b0;
                core_header <= {header_in[639:32], nonce_start};
            end
            if (capture) begin
                hash_q     <= core_hash;
                hash_count <= hash_count + 32'd1;
            end
            if (advance) begin
                nonce_q     <= nonce_q + 32'd1;
                core_header <= {hdr_q, nonce_q + 32'd1};
            end
            if (win) begin
                found     <= 1'b1;
                nonce_out <= nonce_q;
            end
            if (aborting) found <= 1'b0;
        end
    end

endmodule
